dispense_timer: RTL and testbench
=================================

// Module: dispense_timer
// PURPOSE
//  Responder side of the FSM timer handshake. The FSM requests a timed dispense
//  with start_timer plus ing_type. This block counts the ingredient-specific
//  duration and pulses t_expired back to the FSM for exactly one cycle.
//  It sits between the recipe FSM and the valve/ingredient outputs.
// PARAMETERS
//  PRESCALE  50_000_000  clk cycles per duration tick (>=1); 1 s at 50 MHz
//  CNT_W     8           width of the duration/remaining counters
//  DUR0..DUR7 3,5,4,2,6,1,8,0  duration in ticks for ing_type 0..7 (CNT_W bits)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start_timer  in   1      request from FSM; level, may be held high many cycles
//  ing_type     in   3      ingredient code, sampled on the start edge only
//  t_expired    out  1      one-cycle pulse: requested duration elapsed
//  busy         out  1      1 while a dispense is timing (state != IDLE)
//  remaining    out  CNT_W  ticks left, for display; 0 when idle
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE; t_expired=0, busy=0, remaining=0;
//    presc=0; start_d=0. Release is synchronous to the next clk edge.
//  - Start detect: start_d <= start_timer each cycle.
//    - A start event is start_timer & ~start_d (rising edge).
//    - A level held high triggers exactly once.
//  - States: IDLE, RUN, DONE. All outputs are registered.
//  - IDLE --start event--> load D = DUR[ing_type], presc <= 0.
//    - If D!=0: remaining <= D and go to RUN.
//    - If D==0: go directly to DONE.
//  - RUN: presc increments each cycle.
//    - When presc==PRESCALE-1: presc <= 0, remaining <= remaining-1.
//    - If remaining==1 at that wrap: go to DONE (remaining becomes 0).
//  - DONE: t_expired=1 for exactly this one cycle.
//    - Next state is IDLE, unless a start event occurs in the DONE cycle.
//  - Latency: start edge sampled at edge E0 -> t_expired high for the one cycle
//    following edge E0 + D*PRESCALE. For D==0, that is the cycle after E0.
//  - Restart: a start event in RUN reloads D from the new ing_type, clears presc
//    and keeps RUN. The old request is abandoned and no t_expired is emitted for it.
//  - Start event during DONE: the pulse still completes this cycle. The new
//    request loads as from IDLE (RUN, or DONE again if D==0).
//  - ing_type changes while in RUN are ignored; it is latched only on the start edge.
//  - remaining never underflows; it holds 0 in IDLE and DONE.
//  - Reset mid-RUN: the request is aborted immediately and no t_expired is
//    produced. A start_timer still high after reset release counts as a new
//    edge, because start_d was cleared.
//  - busy = (state==RUN)|(state==DONE).
// TESTING (bench: PRESCALE=4, default DURs, clk period 2 ns)
//  1. Reset, then pulse start_timer, ing_type=0 (D=3) -> busy at E0+1;
//     remaining 3,2,1; t_expired high exactly 1 cycle after edge E0+12; then IDLE.
//  2. ing_type=7 (D=0) start -> t_expired pulse in the cycle right after E0;
//     remaining stays 0; busy high for that 1 cycle only.
//  3. Hold start_timer high 40 cycles with ing_type=5 (D=1) -> exactly one
//     t_expired pulse, after edge E0+4; no retrigger while held.
//  4. Start ing_type=6 (D=8), then at E0+10 start ing_type=3 (D=2) ->
//     no pulse for the first request; t_expired after edge E0+10+8.
//  5. Start ing_type=1, assert reset at E0+7 for 3 cycles -> all outputs 0
//     during reset; no t_expired afterwards with start_timer low.
//  6. Start event in the DONE cycle with ing_type=3 -> the DONE pulse is seen;
//     a second pulse follows 8 cycles later; busy stays high throughout.

Source files
------------

// File: rtl/dispense_timer.sv
// Timed-dispense responder: counts DUR[ing_type] ticks of PRESCALE clocks and pulses t_expired once.
// Latency: t_expired is high in the cycle after edge E0 + D*PRESCALE (E0 = start edge sample).
// Backpressure: none; a new start edge in RUN or DONE abandons or follows the current request.
module dispense_timer #(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter int unsigned CNT_W    = 8,
    parameter logic [CNT_W-1:0] DUR0 = CNT_W'(3),
    parameter logic [CNT_W-1:0] DUR1 = CNT_W'(5),
    parameter logic [CNT_W-1:0] DUR2 = CNT_W'(4),
    parameter logic [CNT_W-1:0] DUR3 = CNT_W'(2),
    parameter logic [CNT_W-1:0] DUR4 = CNT_W'(6),
    parameter logic [CNT_W-1:0] DUR5 = CNT_W'(1),
    parameter logic [CNT_W-1:0] DUR6 = CNT_W'(8),
    parameter logic [CNT_W-1:0] DUR7 = CNT_W'(0)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [2:0]       ing_type,
    output logic             t_expired,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             start_d;
    logic             start_ev;
    logic             presc_wrap;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] dur_sel;

    assign start_ev   = start_timer & ~start_d;
    assign presc_wrap = (presc == PW'(PRESCALE - 1));

    always_comb begin
        dur_sel = DUR0;
        case (ing_type)
            3'd0:    dur_sel = DUR0;
            3'd1:    dur_sel = DUR1;
            3'd2:    dur_sel = DUR2;
            3'd3:    dur_sel = DUR3;
            3'd4:    dur_sel = DUR4;
            3'd5:    dur_sel = DUR5;
            3'd6:    dur_sel = DUR6;
            default: dur_sel = DUR7;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start edge wins in every state; a zero duration skips straight to the pulse.
    always_comb begin
        state_nxt = state;
        if (start_ev) begin
            state_nxt = (dur_sel == '0) ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (presc_wrap && remaining == CNT_W'(1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == RUN) | (state == DONE);
        t_expired = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d   <= 1'b0;
            presc     <= '0;
            remaining <= '0;
        end else begin
            start_d <= start_timer;
            if (start_ev) begin
                presc     <= '0;
                remaining <= dur_sel;
            end else if (state == RUN) begin
                if (presc_wrap) begin
                    presc     <= '0;
                    remaining <= remaining - 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispense_timer.sv
// Self-checking bench for dispense_timer with PRESCALE=4 and default durations.
module tb_dispense_timer;

    localparam int P = 4;
    localparam int DURS [8] = '{3, 5, 4, 2, 6, 1, 8, 0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_timer = 1'b0;
    logic [2:0] ing_type = 3'd0;
    logic       t_expired;
    logic       busy;
    logic [7:0] remaining;

    int n_cmp = 0;
    int n_bad = 0;

    dispense_timer #(.PRESCALE(P), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start_timer(start_timer),
        .ing_type(ing_type),
        .t_expired(t_expired),
        .busy(busy),
        .remaining(remaining)
    );

    always #1 clk = ~clk;

    // Reference model: a request is just (start edge, duration); the pulse edge and the
    // displayed ticks follow arithmetically from those two numbers.
    int         cyc = 0;
    int         t0 = 0;
    int         dur = 0;
    int         pulse_at = -1;
    bit         prev_s = 1'b0;
    logic       e_t = 1'b0;
    logic       e_b = 1'b0;
    logic [7:0] e_r = 8'd0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            prev_s   = 1'b0;
            dur      = 0;
            t0       = 0;
            pulse_at = -1;
        end else begin
            if (start_timer && !prev_s) begin
                t0       = cyc;
                dur      = DURS[ing_type];
                pulse_at = cyc + dur * P;
            end
            prev_s = start_timer;
        end
        e_t = (pulse_at == cyc);
        e_b = (pulse_at >= cyc);
        e_r = (pulse_at > cyc) ? 8'(dur - (cyc - t0) / P) : 8'd0;
    end

    task automatic quiet();
        start_timer = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_timer = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({t_expired, busy, remaining} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_state got t=%b b=%b r=%0d want all 0", t_expired, busy, remaining);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e0, np, pc;
        quiet();
        ing_type = 3'd0; start_timer = 1'b1; e0 = cyc + 1; np = 0; pc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_timer = 1'b0;
            n_cmp++;
            if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL basic cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (t_expired) begin np++; pc = cyc; end
        end
        n_cmp++;
        if (np != 1 || pc != e0 + 12) begin
            n_bad++;
            $display("FAIL basic_pulse got %0d pulses at +%0d want 1 at +12", np, pc - e0);
        end
    endtask

    task automatic test_zero();
        int e0, np, pc, nb;
        quiet();
        ing_type = 3'd7; start_timer = 1'b1; e0 = cyc + 1; np = 0; pc = -1; nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_timer = 1'b0;
            n_cmp++;
            if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL zero cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (t_expired) begin np++; pc = cyc; end
            if (busy) nb++;
        end
        n_cmp++;
        if (np != 1 || pc != e0 || nb != 1) begin
            n_bad++;
            $display("FAIL zero_pulse got %0d pulses at +%0d busy=%0d want 1 at +0 busy=1", np, pc - e0, nb);
        end
    endtask

    task automatic test_hold();
        int e0, np, pc;
        quiet();
        ing_type = 3'd5; start_timer = 1'b1; e0 = cyc + 1; np = 0; pc = -1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (i == 39) start_timer = 1'b0;
            n_cmp++;
            if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL hold cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (t_expired) begin np++; pc = cyc; end
        end
        n_cmp++;
        if (np != 1 || pc != e0 + 4) begin
            n_bad++;
            $display("FAIL hold_pulse got %0d pulses at +%0d want 1 at +4", np, pc - e0);
        end
    endtask

    task automatic test_restart();
        int e0, np, pc;
        quiet();
        ing_type = 3'd6; start_timer = 1'b1; e0 = cyc + 1; np = 0; pc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start_timer = 1'b0;
            n_cmp++;
            if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL restart cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (t_expired) begin np++; pc = cyc; end
            if (cyc == e0 + 9) begin
                start_timer = 1'b1;
                ing_type = 3'd3;
            end else if (cyc > e0 + 10) begin
                ing_type = 3'($urandom_range(0, 7));
            end
        end
        n_cmp++;
        if (np != 1 || pc != e0 + 18) begin
            n_bad++;
            $display("FAIL restart_pulse got %0d pulses at +%0d want 1 at +18", np, pc - e0);
        end
    endtask

    task automatic test_reset_mid();
        int e0, np;
        quiet();
        ing_type = 3'd1; start_timer = 1'b1; e0 = cyc + 1; np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_timer = 1'b0;
            n_cmp++;
            if (reset) begin
                if ({t_expired, busy, remaining} !== 10'd0) begin
                    n_bad++;
                    $display("FAIL reset_mid cyc=%0d got t=%b b=%b r=%0d want all 0",
                             cyc, t_expired, busy, remaining);
                end
            end else if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (t_expired) np++;
            if (cyc == e0 + 6) reset = 1'b1;
            if (cyc == e0 + 9) reset = 1'b0;
        end
        n_cmp++;
        if (np != 0) begin
            n_bad++;
            $display("FAIL reset_mid_pulse got %0d pulses want 0", np);
        end
    endtask

    task automatic test_done_restart();
        int e0, e1, np, p1, p2, nb;
        quiet();
        ing_type = 3'd3; start_timer = 1'b1; e0 = cyc + 1; e1 = -100; np = 0; p1 = -1; p2 = -1; nb = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            start_timer = 1'b0;
            n_cmp++;
            if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL done_restart cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
            if (busy && cyc > e0 && cyc <= e0 + 17) nb++;
            if (t_expired) begin
                np++;
                if (np == 1) begin
                    p1 = cyc;
                    start_timer = 1'b1;
                    ing_type = 3'd3;
                    e1 = cyc + 1;
                end else begin
                    p2 = cyc;
                end
            end
        end
        n_cmp++;
        if (np != 2 || p1 != e0 + 8 || p2 != e1 + 8 || nb != 17) begin
            n_bad++;
            $display("FAIL done_restart_pulses got n=%0d at +%0d,+%0d busy=%0d want n=2 at +8,+17 busy=17",
                     np, p1 - e0, p2 - e0, nb);
        end
    endtask

    task automatic test_random();
        quiet();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) start_timer = ~start_timer;
            if ($urandom_range(0, 3) == 0) ing_type = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_cmp++;
            if (reset) begin
                if ({t_expired, busy, remaining} !== 10'd0) begin
                    n_bad++;
                    $display("FAIL random_reset cyc=%0d got t=%b b=%b r=%0d want all 0",
                             cyc, t_expired, busy, remaining);
                end
            end else if ({t_expired, busy, remaining} !== {e_t, e_b, e_r}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got t=%b b=%b r=%0d want t=%b b=%b r=%0d",
                         cyc, t_expired, busy, remaining, e_t, e_b, e_r);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_hold();
        test_restart();
        test_reset_mid();
        test_done_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
